// File: rtl/real_bits_serializer.sv
// real_bits_serializer
//   Splits a 64-bit real bit pattern ($realtobits encoding) into BEAT_W-wide
//   beats. Beats go out most significant first, with a valid/ready handshake
//   on both sides. A new word can be accepted on the same edge that the last
//   beat of the previous word is accepted, so back-to-back words have no gap.
//
//   Optional feature macro: REAL_BITS_SER_CLASSIFY_EN
//     When defined, adds out_class, which reports the class of the held word
//     (00 normal/subnormal, 01 zero, 10 infinity, 11 NaN).
//
//   Ports
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     in_bits    [64:1] real bit pattern (64 sign, 63:53 exponent, 52:1 mantissa)
//     in_valid   in_bits is valid
//     in_ready   word is accepted when in_valid & in_ready
//     out_beat   current beat
//     out_valid  out_beat is valid
//     out_ready  beat is accepted when out_valid & out_ready
//     out_first  current beat is beat 0 of its word
//     out_last   current beat is the last beat of its word
//     busy       a word is held (same as out_valid)
//     out_class  class of the held word (only with the macro defined)
//
//   state | meaning
//   IDLE  | no word held, ready for input
//   SEND  | word held, presenting beat k
module real_bits_serializer #(
  parameter int BEAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [64:1]       in_bits,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BEAT_W-1:0] out_beat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last,
  output logic              busy
`ifdef REAL_BITS_SER_CLASSIFY_EN
  ,
  output logic [1:0]        out_class
`endif
);

  localparam int NBEATS = 64 / BEAT_W;
  localparam int KW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NBEATS - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t      state;
  logic [KW-1:0] k;
  // The held word is shifted left by one beat after each accept, so the
  // current beat always sits in the top BEAT_W bits. This presents the same
  // value as indexing beat k out of the unshifted word.
  logic [63:0] hold;
  logic        load;
  logic        adv;

  assign adv      = out_valid & out_ready;
  assign in_ready = (state == IDLE) | (adv & out_last);
  assign load     = in_valid & in_ready;
  assign busy     = out_valid;
  assign out_beat = hold[63 -: BEAT_W];

`ifdef REAL_BITS_SER_CLASSIFY_EN
  // The sign bit is ignored, so -0.0 is classified as zero.
  function automatic logic [1:0] classify(input logic [63:1] b);
    if (b[63:53] == 11'h7FF)
      return (b[52:1] == '0) ? 2'b10 : 2'b11;
    else if (b[63:53] == 11'h000 && b[52:1] == '0)
      return 2'b01;
    else
      return 2'b00;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      hold      <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
`ifdef REAL_BITS_SER_CLASSIFY_EN
      out_class <= 2'b00;
`endif
    end else if (load) begin
      // Covers both a load from IDLE and a reload on the last-beat accept.
      state     <= SEND;
      k         <= '0;
      hold      <= in_bits;
      out_valid <= 1'b1;
      out_first <= 1'b1;
      out_last  <= (NBEATS == 1);
`ifdef REAL_BITS_SER_CLASSIFY_EN
      out_class <= classify(in_bits[63:1]);
`endif
    end else if (adv) begin
      if (out_last) begin
        state     <= IDLE;
        k         <= '0;
        out_valid <= 1'b0;
        out_first <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        k         <= k + KW'(1);
        hold      <= hold << BEAT_W;
        out_first <= 1'b0;
        out_last  <= ((k + KW'(1)) == K_LAST);
      end
    end
  end

endmodule

// File: tb/tb_real_bits_serializer.sv
module tb_real_bits_serializer;

  localparam logic [63:0] W_ONE = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] W_PI  = 64'h4009_21FB_5444_2D18;
  localparam logic [63:0] W_M2  = 64'hC000_0000_0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic [64:1] in_bits = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_beat;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_first;
  logic        out_last;
  logic        busy;

  logic [64:1] in_bits64 = '0;
  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [63:0] out_beat64;
  logic        out_valid64;
  logic        out_ready64 = 1'b0;
  logic        out_first64;
  logic        out_last64;
  logic        busy64;
`ifdef REAL_BITS_SER_CLASSIFY_EN
  logic [1:0]  out_class;
  logic [1:0]  out_class64;
`endif

  real_bits_serializer #(.BEAT_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_bits(in_bits), .in_valid(in_valid),
    .in_ready(in_ready), .out_beat(out_beat), .out_valid(out_valid),
    .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
    .busy(busy)
`ifdef REAL_BITS_SER_CLASSIFY_EN
    , .out_class(out_class)
`endif
  );

  real_bits_serializer #(.BEAT_W(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_bits(in_bits64), .in_valid(in_valid64),
    .in_ready(in_ready64), .out_beat(out_beat64), .out_valid(out_valid64),
    .out_ready(out_ready64), .out_first(out_first64), .out_last(out_last64),
    .busy(busy64)
`ifdef REAL_BITS_SER_CLASSIFY_EN
    , .out_class(out_class64)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Scoreboards: {first, last, beat}
  logic [17:0] q16[$];
  logic [65:0] q64[$];
  logic [17:0] e16;
  logic [65:0] e64;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push16(input logic [63:0] w);
    for (int b = 0; b < 4; b++)
      q16.push_back({(b == 0), (b == 3), w[63 - 16*b -: 16]});
  endtask

  task automatic drain16();
    int n = 0;
    while (q16.size() != 0 && n < 40) begin
      step();
      n++;
    end
    chk("drain16", 64'(q16.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q16.size() == 0) begin
        chk("beat16_unexpected", 64'(q16.size()), 64'd1);
      end else begin
        e16 = q16.pop_front();
        chk("beat16", {46'b0, out_first, out_last, out_beat}, {46'b0, e16});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid64 && out_ready64) begin
      if (q64.size() == 0) begin
        chk("beat64_unexpected", 64'(q64.size()), 64'd1);
      end else begin
        e64 = q64.pop_front();
        chk("beat64", out_beat64, e64[63:0]);
        chk("flags64", {62'b0, out_first64, out_last64}, {62'b0, e64[65:64]});
      end
    end
  end

  initial begin
    int pat[6];
`ifdef REAL_BITS_SER_CLASSIFY_EN
    logic [63:0] cw[4];
    logic [1:0]  cc[4];
`endif
    logic [63:0] w64[4];

    // Reset
    #2 rst_n = 1'b0;
    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_first", 64'(out_first), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_beat", 64'(out_beat), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_in_ready64", 64'(in_ready64), 64'd1);

    // 1: single word 1.0
    step();
    in_bits = W_ONE; in_valid = 1'b1; out_ready = 1'b1;
    push16(W_ONE);
    step();
    in_valid = 1'b0;
    in_bits = 64'hDEAD_BEEF_0BAD_F00D;
    for (int k = 0; k < 4; k++) begin
      chk("t1_out_valid", 64'(out_valid), 64'd1);
      chk("t1_out_first", 64'(out_first), 64'(k == 0));
      chk("t1_in_ready", 64'(in_ready), 64'(k == 3));
      step();
    end
    chk("t1_idle", 64'(out_valid), 64'd0);
    drain16();

    // 2: back-to-back pi then -2.0
    in_bits = W_PI; in_valid = 1'b1;
    push16(W_PI);
    push16(W_M2);
    step();
    in_bits = W_M2;
    for (int i = 0; i < 8; i++) begin
      chk("t2_out_valid", 64'(out_valid), 64'd1);
      chk("t2_in_ready", 64'(in_ready), 64'(i == 3 || i == 7));
      step();
      if (i == 3) in_valid = 1'b0;
    end
    chk("t2_idle", 64'(out_valid), 64'd0);
    drain16();

    // 3: back-pressure 1,0,0,1,1,1
    pat = '{1, 0, 0, 1, 1, 1};
    in_bits = W_ONE; in_valid = 1'b1; out_ready = 1'b1;
    push16(W_ONE);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      out_ready = (pat[i] != 0);
      chk("t3_out_valid", 64'(out_valid), 64'd1);
      if (i >= 1 && i <= 3) begin
        chk("t3_hold_beat", 64'(out_beat), 64'd0);
        chk("t3_hold_first", 64'(out_first), 64'd0);
        chk("t3_hold_last", 64'(out_last), 64'd0);
      end
      if (i == 5) chk("t3_last", 64'(out_last), 64'd1);
      step();
    end
    out_ready = 1'b1;
    chk("t3_idle", 64'(out_valid), 64'd0);
    drain16();

    // 4: reset mid-word
    in_bits = W_PI; in_valid = 1'b1;
    push16(W_PI);
    step();
    in_valid = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t4_out_valid", 64'(out_valid), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_out_last", 64'(out_last), 64'd0);
    chk("t4_out_beat", 64'(out_beat), 64'd0);
    q16.delete();
    step();
    rst_n = 1'b1;
    #1;
    chk("t4_in_ready", 64'(in_ready), 64'd1);
    chk("t4_still_idle", 64'(out_valid), 64'd0);
    in_bits = W_M2; in_valid = 1'b1;
    push16(W_M2);
    step();
    in_valid = 1'b0;
    chk("t4_first", 64'(out_first), 64'd1);
    chk("t4_beat0", 64'(out_beat), 64'hC000);
    drain16();

`ifdef REAL_BITS_SER_CLASSIFY_EN
    // 5: classification
    cw = '{64'h7FF8_0000_0000_0000, 64'hFFF0_0000_0000_0000,
           64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001};
    cc = '{2'b11, 2'b10, 2'b01, 2'b00};
    for (int j = 0; j < 4; j++) begin
      in_bits = cw[j]; in_valid = 1'b1;
      push16(cw[j]);
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        chk("t5_class", 64'(out_class), 64'(cc[j]));
        step();
      end
    end
    drain16();
`endif

    // 6: BEAT_W=64, one word per cycle
    w64 = '{W_ONE, W_PI, W_M2, 64'h0123_4567_89AB_CDEF};
    out_ready64 = 1'b1;
    in_valid64 = 1'b1;
    in_bits64 = w64[0];
    q64.push_back({2'b11, w64[0]});
    step();
    for (int i = 1; i < 4; i++) begin
      chk("t6_out_valid", 64'(out_valid64), 64'd1);
      chk("t6_in_ready", 64'(in_ready64), 64'd1);
      chk("t6_backlog", 64'(q64.size()), 64'd1);
`ifdef REAL_BITS_SER_CLASSIFY_EN
      chk("t6_class", 64'(out_class64), 64'd0);
`endif
      in_bits64 = w64[i];
      q64.push_back({2'b11, w64[i]});
      step();
    end
    in_valid64 = 1'b0;
    step();
    chk("t6_idle", 64'(out_valid64), 64'd0);
    chk("t6_drain", 64'(q64.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/real_bits_serializer.md
# real_bits_serializer

Serializes 64-bit real bit patterns (the `$realtobits` encoding driven onto a `[64:1]` wire by a real-to-bits driver stage) into narrower beats with a valid/ready handshake. It sits directly downstream of the driver stage and feeds a narrow link whose far end reassembles the word for a `$bitstoreal` receiver. One 64-bit word is held internally while its beats are emitted, most significant beat first.

## Interface
Parameters:
- `BEAT_W`, default 16: beat width. Legal values are 8, 16, 32 and 64. `NBEATS = 64/BEAT_W`.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `in_bits`  input  [64:1]  real bit pattern. Bit 64 is the sign, bits 63:53 the exponent, bits 52:1 the mantissa.
- `in_valid`  input  1  `in_bits` is valid.
- `in_ready`  output  1  word accepted when `in_valid & in_ready`.
- `out_beat`  output  [BEAT_W-1:0]  current beat.
- `out_valid`  output  1  `out_beat` is valid.
- `out_ready`  input  1  beat accepted when `out_valid & out_ready`.
- `out_first`  output  1  current beat is beat 0 of its word.
- `out_last`  output  1  current beat is beat `NBEATS-1`.
- `busy`  output  1  a word is held (equal to `out_valid`).
- `out_class`  output  [1:0]  class of the held word; present only with the macro described under Configuration.

## Operation
State machine:
- **IDLE:** no word held. `in_ready`=1.
  - On input accept: capture `in_bits` into the holding register, set the beat index to 0, go to SEND.
- **SEND:** beat `k` is presented as `out_beat = hold[64-k*BEAT_W -: BEAT_W]`.
  - On an output accept with `k < NBEATS-1`: increment `k`.
  - On an output accept with `k == NBEATS-1` (last beat):
    - if `in_valid` is high, capture the new word, set `k`=0 and stay in SEND;
    - otherwise go to IDLE.

Handshake and output rules:
- `in_ready = (state==IDLE) | (out_valid & out_ready & out_last)`. This is a combinational path from `out_ready`, and it allows back-to-back words with no bubble.
- `out_first = (k==0)` while in SEND. `out_last = (k==NBEATS-1)` while in SEND. With `BEAT_W=64`, both are high on the single beat.
- `out_beat` and the flags are held stable while `out_valid & ~out_ready`.
- `in_bits` is sampled only on an input accept. Changes on `in_bits` at any other time have no effect.
- No arithmetic is done on the pattern; bits pass through unchanged.

Reset:
- Reset values: state IDLE, `k`=0, holding register 0, `out_valid`=0, `out_first`=0, `out_last`=0, `out_beat`=0, `busy`=0, `out_class`=0, `in_ready`=1 once `rst_n` is high.
- An assertion of `rst_n` in the middle of a word discards the word. No partial completion, and no `out_last` is emitted for it.

## Timing
- Input accept at edge N: beat 0 is valid after edge N (visible in cycle N+1).
- With `out_ready` held high, beat `k` is accepted at edge N+1+k.
- Throughput is one word per `NBEATS` cycles with no idle cycle between words.
- Back-pressure: each cycle with `out_ready` low adds exactly one cycle. The beat index does not advance.
- `out_valid` never deasserts without an accept, except on reset.

## Configuration
Macro: `REAL_BITS_SER_CLASSIFY_EN`.

- **Defined:** the `out_class` port exists. It is registered on input accept and held for the whole word, using E = `in_bits[63:53]` and M = `in_bits[52:1]`:
  - 2'b01 zero: E=0 and M=0; the sign is ignored, so -0.0 is included.
  - 2'b10 infinity: E=11'h7FF and M=0.
  - 2'b11 NaN: E=11'h7FF and M≠0.
  - 2'b00 otherwise: normal or subnormal.
- **Undefined:** the port and its register are absent. All other behaviour is identical.

## Test plan
1. `BEAT_W`=16, `in_bits`=64'h3FF0_0000_0000_0000 (1.0), `out_ready`=1 → beats 16'h3FF0, 16'h0000, 16'h0000, 16'h0000 on four consecutive cycles; `out_first` on beat 0 and `out_last` on beat 3; `in_ready` low for beats 0–2.
2. Back-to-back: 64'h4009_21FB_5444_2D18 (pi) then 64'hC000_0000_0000_0000 (-2.0) with `in_valid` held → 8 consecutive beats 4009, 21FB, 5444, 2D18, C000, 0000, 0000, 0000, with no gap; the second word is accepted on the same edge as beat 3 of the first.
3. Back-pressure: `out_ready` pattern 1,0,0,1,1,1 on word 1.0 → beat 1 (16'h0000) held stable for 3 cycles; `out_last` is accepted on the 6th cycle.
4. Reset mid-word: assert `rst_n`=0 asynchronously after beat 1 → `out_valid`=0 and `busy`=0 immediately; after release, `in_ready`=1 and the next word starts with `out_first`.
5. With `REAL_BITS_SER_CLASSIFY_EN` defined:
   - 64'h7FF8_0000_0000_0000 → class 2'b11;
   - 64'hFFF0_0000_0000_0000 → class 2'b10;
   - 64'h8000_0000_0000_0000 → class 2'b01;
   - 64'h0000_0000_0000_0001 → class 2'b00.
6. `BEAT_W`=64: word 64'h3FF0_0000_0000_0000 → a single beat with `out_first`=`out_last`=1; with `out_ready`=1 and `in_valid` held, one word is accepted every cycle.
